lsu_access_ctrl: RTL and testbench
==================================

Name: lsu_access_ctrl

Overview:
- Load/store front-end sitting between the execute stage and the LSU data SRAM port (req/wen/addr/wdata/wmask in, rvalid/rdata out).
- Accepts one memory op per handshake and checks alignment.
- Drives a single-cycle SRAM request with a word-aligned address, byte mask and lane-replicated write data.
- For loads, waits for rvalid, then extracts and sign/zero-extends the result; hands a response to writeback over a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT_R before aborting the load with err.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  execute stage presents an op.
- in_ready  output  1  block can accept an op; high only in IDLE.
- in_op  input  2  01 = load, 10 = store; 00 and 11 are illegal.
- in_funct3  input  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- in_addr  input  32  byte address.
- in_wdata  input  32  rs2 value for stores.
- in_rd  input  5  destination register tag, passed through.
- mem_req  output  1  SRAM request; high exactly one cycle (state REQ).
- mem_wen  output  1  1 = write.
- mem_addr  output  32  in_addr with bits [1:0] cleared.
- mem_wdata  output  32  lane-replicated store data.
- mem_wmask  output  4  byte-enable mask.
- mem_rvalid  input  1  read data valid, single-cycle pulse.
- mem_rdata  input  32  read word; meaningful only while mem_rvalid = 1.
- out_valid  output  1  response available to writeback.
- out_ready  input  1  writeback accepts the response.
- out_rdata  output  32  extended load data; 0 for stores and errors.
- out_rd  output  5  captured in_rd.
- out_rf_wen  output  1  1 only for a successful load.
- out_err  output  1  misaligned, illegal or timed-out op.

Behaviour:
- Reset: state = IDLE. All outputs 0 except in_ready = 1. The timeout counter is cleared.
- Reset mid-operation aborts the op and no response is produced. An mem_rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - Capture happens on in_valid && in_ready.
  - Misaligned means H with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal means in_op of 00/11, an undefined funct3, or a store with BU/HU.
  - Misaligned or illegal goes to RESP with out_err = 1 and out_rf_wen = 0; no mem_req is ever issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1 for this one cycle; mem_addr, mem_wen, mem_wdata and mem_wmask are registered and stable.
  - Store goes to RESP (the write commits at this edge); load goes to WAIT_R.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, mask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, mask = 4'b0011 << addr[1:0].
  - SW: wdata = rs2, mask = 4'b1111.
- Loads: mem_wen = 0 and mem_wmask = 0.
- WAIT_R:
  - The counter increments each cycle.
  - On mem_rvalid: shifted = mem_rdata >> (8*addr[1:0]). B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through. Result is registered into out_rdata with out_rf_wen = 1, then go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: out_err = 1, out_rdata = 0, go to RESP.
  - Nominal latency: rvalid arrives 2 cycles after the REQ cycle.
- RESP:
  - out_valid = 1; all out_* are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE and clear out_valid, out_rf_wen and out_err.
- Latency, in_accept edge to out_valid: store 2 cycles; aligned load 2 + SRAM latency (4 nominal); error 1.
- mem_rvalid outside WAIT_R is ignored.
- Only one op is ever outstanding; in_ready = 0 in REQ, WAIT_R and RESP.

Test Plan:
- LW at 0x80000010, SRAM word 0xDEADBEEF -> one mem_req with mem_addr 0x80000010 and mem_wen 0; out_valid 4 cycles after accept with out_rdata 0xDEADBEEF and out_rf_wen 1.
- LB at 0x80000013 and LBU at the same address, word 0x80FF1234 -> out_rdata 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x80000022, rs2 0x0000ABCD -> mem_wdata 0xABCDABCD, mem_wmask 4'b1100, mem_wen 1, mem_addr 0x80000020; response has out_rf_wen 0 and out_err 0.
- LW at 0x80000002 -> no mem_req ever asserted; out_valid the next cycle with out_err 1 and out_rdata 0.
- Load with mem_rvalid held 0 -> after 16 WAIT_R cycles, out_err 1 and out_rf_wen 0; a later stray rvalid is ignored and in_ready = 1.
- out_ready low for 5 cycles during RESP -> out_* stable and in_ready 0 throughout. Separately, rst pulsed in WAIT_R -> IDLE with all outputs at reset values, and the subsequent rvalid produces no out_valid.

Source files
------------

// File: rtl/lsu_access_ctrl_if.sv
// Bundle of the execute-side op handshake, the SRAM port and the writeback
// response handshake of the load/store front-end.
interface lsu_access_ctrl_if;
  // execute stage -> front-end
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  // front-end <-> data SRAM
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // front-end -> writeback
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_rf_wen;
  logic        out_err;

  // Environment side: drives ops, SRAM read data and writeback ready.
  modport master (
    output in_valid, in_op, in_funct3, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_rvalid, mem_rdata,
    input  out_valid, out_rdata, out_rd, out_rf_wen, out_err,
    output out_ready
  );

  // Front-end side.
  modport slave (
    input  in_valid, in_op, in_funct3, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_rvalid, mem_rdata,
    output out_valid, out_rdata, out_rd, out_rf_wen, out_err,
    input  out_ready
  );
endinterface

// File: rtl/lsu_access_ctrl.sv
// Load/store front-end: accepts one op at a time, screens it for alignment
// and legality, issues a single-cycle SRAM request, extends load data and
// returns a response to writeback. Every output is a flop.
module lsu_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  lsu_access_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10,
    RESP   = 2'b11
  } state_t;

  state_t      state_r;
  logic        in_ready_r;
  logic        mem_req_r;
  logic        mem_wen_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;
  logic        out_valid_r;
  logic [31:0] out_rdata_r;
  logic [4:0]  out_rd_r;
  logic        out_rf_wen_r;
  logic        out_err_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic        is_load_r;
  logic [CNT_W-1:0] cnt_r;

  logic        misaligned_s;
  logic        illegal_s;
  logic        is_store_s;

  // Replicate the store operand across every byte lane it may land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] lanes;
    case (f3)
      3'b000:  lanes = {4{rs2[7:0]}};
      3'b001:  lanes = {2{rs2[15:0]}};
      3'b010:  lanes = rs2;
      default: lanes = 32'h0000_0000;
    endcase
    return lanes;
  endfunction

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] mask;
    case (f3)
      3'b000:  mask = 4'b0001 << off;
      3'b001:  mask = 4'b0011 << off;
      3'b010:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Move the addressed bytes down to bit 0 and sign/zero-extend them.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  result = shifted;
      3'b100:  result = {24'h00_0000, shifted[7:0]};
      3'b101:  result = {16'h0000, shifted[15:0]};
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

  // Screen the presented op for an unsupported encoding or a misaligned address.
  always_comb begin
    misaligned_s = 1'b0;
    illegal_s    = 1'b0;
    is_store_s   = (bus.in_op == OP_STORE);
    case (bus.in_funct3[1:0])
      2'b01:   misaligned_s = bus.in_addr[0];
      2'b10:   misaligned_s = (bus.in_addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    case (bus.in_funct3)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = is_store_s;
      default:                illegal_s = 1'b1;
    endcase
    if ((bus.in_op != OP_LOAD) && (bus.in_op != OP_STORE)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = illegal_s;
    end
  end

  // Op sequencer; owns every registered output and the WAIT_R timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      mem_req_r    <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      mem_wmask_r  <= 4'b0000;
      out_valid_r  <= 1'b0;
      out_rdata_r  <= 32'h0000_0000;
      out_rd_r     <= 5'd0;
      out_rf_wen_r <= 1'b0;
      out_err_r    <= 1'b0;
      funct3_r     <= 3'b000;
      off_r        <= 2'b00;
      is_load_r    <= 1'b0;
      cnt_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            out_rd_r   <= bus.in_rd;
            funct3_r   <= bus.in_funct3;
            off_r      <= bus.in_addr[1:0];
            is_load_r  <= (bus.in_op == OP_LOAD);
            if (illegal_s || misaligned_s) begin
              // Rejected ops never touch the SRAM.
              out_valid_r  <= 1'b1;
              out_err_r    <= 1'b1;
              out_rf_wen_r <= 1'b0;
              out_rdata_r  <= 32'h0000_0000;
              state_r      <= RESP;
            end else begin
              mem_req_r   <= 1'b1;
              mem_wen_r   <= is_store_s;
              mem_addr_r  <= {bus.in_addr[31:2], 2'b00};
              mem_wdata_r <= is_store_s ? store_lanes(bus.in_funct3, bus.in_wdata) : 32'h0000_0000;
              mem_wmask_r <= is_store_s ? store_mask(bus.in_funct3, bus.in_addr[1:0]) : 4'b0000;
              state_r     <= REQ;
            end
          end
        end
        REQ: begin
          mem_req_r <= 1'b0;
          if (is_load_r) begin
            cnt_r   <= '0;
            state_r <= WAIT_R;
          end else begin
            // The write has been committed at this edge.
            out_valid_r  <= 1'b1;
            out_err_r    <= 1'b0;
            out_rf_wen_r <= 1'b0;
            out_rdata_r  <= 32'h0000_0000;
            state_r      <= RESP;
          end
        end
        WAIT_R: begin
          if (bus.mem_rvalid) begin
            out_valid_r  <= 1'b1;
            out_err_r    <= 1'b0;
            out_rf_wen_r <= 1'b1;
            out_rdata_r  <= load_extend(funct3_r, bus.mem_rdata, off_r);
            state_r      <= RESP;
          end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // The TIMEOUT_CYCLES-th silent cycle abandons the load.
            out_valid_r  <= 1'b1;
            out_err_r    <= 1'b1;
            out_rf_wen_r <= 1'b0;
            out_rdata_r  <= 32'h0000_0000;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
            out_rf_wen_r <= 1'b0;
            out_err_r    <= 1'b0;
            in_ready_r   <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          mem_req_r   <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_wen    = mem_wen_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_wmask  = mem_wmask_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_rdata  = out_rdata_r;
  assign bus.out_rd     = out_rd_r;
  assign bus.out_rf_wen = out_rf_wen_r;
  assign bus.out_err    = out_err_r;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Bench for lsu_access_ctrl: a vector table of ops with their expected SRAM
// request and response, a response scoreboard queue, and hand-written
// sequences for timeout follow-up and reset during a pending load.
module tb_lsu_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_access_ctrl_if bus();

  lsu_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;       // SRAM read word
    int          rv_dly;     // rvalid cycle relative to the REQ cycle, -1 = never
    int          hold;       // cycles out_ready stays low in RESP
    bit          exp_req;
    logic [31:0] exp_maddr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    int          exp_lat;    // cycles from accept edge to out_valid
    logic [31:0] exp_rdata;
    logic        exp_rf_wen;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        err;
  } resp_t;

  vec_t  vt[$];
  resp_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL [%0d] %s: got 0x%08h expected 0x%08h", cur, name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    chk({tag, "_mem_req"},    32'(bus.mem_req),    32'd0);
    chk({tag, "_mem_wen"},    32'(bus.mem_wen),    32'd0);
    chk({tag, "_mem_addr"},   bus.mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
    chk({tag, "_mem_wmask"},  32'(bus.mem_wmask),  32'd0);
    chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, "_out_rdata"},  bus.out_rdata,       32'd0);
    chk({tag, "_out_rd"},     32'(bus.out_rd),     32'd0);
    chk({tag, "_out_rf_wen"}, 32'(bus.out_rf_wen), 32'd0);
    chk({tag, "_out_err"},    32'(bus.out_err),    32'd0);
  endtask

  // Present one op, play the SRAM side, then check the response via the scoreboard.
  task automatic run_vec(input vec_t v, input int idx);
    resp_t       e;
    resp_t       got;
    int          cyc;
    int          nreq;
    int          req_cyc;
    bit          done;
    bit          saw_ready;
    logic [31:0] h_rdata;
    logic [4:0]  h_rd;
    logic        h_rf;
    logic        h_err;
    cur = idx;
    e.rdata  = v.exp_rdata;
    e.rd     = 5'(idx + 1);
    e.rf_wen = v.exp_rf_wen;
    e.err    = v.exp_err;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_op     = v.op;
    bus.in_funct3 = v.f3;
    bus.in_addr   = v.addr;
    bus.in_wdata  = v.wdata;
    bus.in_rd     = 5'(idx + 1);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_addr   = $urandom;
    bus.in_wdata  = $urandom;
    bus.in_rd     = 5'($urandom);
    cyc = 1; nreq = 0; req_cyc = -100; done = 1'b0; saw_ready = 1'b0;
    while (!done && cyc < 40) begin
      if (bus.in_ready) saw_ready = 1'b1;
      if (bus.mem_req) begin
        nreq++;
        req_cyc = cyc;
        chk("mem_addr",  bus.mem_addr,        v.exp_maddr);
        chk("mem_wen",   32'(bus.mem_wen),    32'(v.exp_wen));
        chk("mem_wmask", 32'(bus.mem_wmask),  32'(v.exp_wmask));
        if (v.exp_wen) chk("mem_wdata", bus.mem_wdata, v.exp_wdata);
      end
      if (bus.out_valid) begin
        done = 1'b1;
      end else begin
        if (v.rv_dly >= 0 && nreq > 0 && cyc == req_cyc + v.rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = v.word;
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.mem_rvalid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL [%0d] out_valid_wait: got no out_valid within 40 cycles expected one after %0d", idx, v.exp_lat);
    end
    chk("latency",        32'(cyc),       32'(v.exp_lat));
    chk("mem_req_cycles", 32'(nreq),      v.exp_req ? 32'd1 : 32'd0);
    if (v.exp_req) chk("mem_req_cycle", 32'(req_cyc), 32'd1);
    chk("in_ready_busy",  32'(saw_ready), 32'd0);
    // Hold the response back; a stray rvalid here must have no effect.
    h_rdata = bus.out_rdata; h_rd = bus.out_rd; h_rf = bus.out_rf_wen; h_err = bus.out_err;
    for (int k = 0; k < v.hold; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      chk("hold_valid",    32'(bus.out_valid),  32'd1);
      chk("hold_in_ready", 32'(bus.in_ready),   32'd0);
      chk("hold_rdata",    bus.out_rdata,       h_rdata);
      chk("hold_rd",       32'(bus.out_rd),     32'(h_rd));
      chk("hold_rf_wen",   32'(bus.out_rf_wen), 32'(h_rf));
      chk("hold_err",      32'(bus.out_err),    32'(h_err));
    end
    bus.mem_rvalid = 1'b0;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL [%0d] scoreboard: got a response expected none queued", idx);
    end else begin
      got = sb_q.pop_front();
      chk("out_rdata",  bus.out_rdata,       got.rdata);
      chk("out_rd",     32'(bus.out_rd),     32'(got.rd));
      chk("out_rf_wen", 32'(bus.out_rf_wen), 32'(got.rf_wen));
      chk("out_err",    32'(bus.out_err),    32'(got.err));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid",  32'(bus.out_valid),  32'd0);
    chk("post_out_rf_wen", 32'(bus.out_rf_wen), 32'd0);
    chk("post_out_err",    32'(bus.out_err),    32'd0);
    chk("post_in_ready",   32'(bus.in_ready),   32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Field order: op f3 addr wdata word rv_dly hold | req maddr wen wdata wmask lat rdata rf_wen err
    vt.push_back('{2'b01, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2, 0,   1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 4, 32'hDEAD_BEEF, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b000, 32'h8000_0013, 32'h0, 32'h80FF_1234, 2, 0,   1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 4, 32'hFFFF_FF80, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b100, 32'h8000_0013, 32'h0, 32'h80FF_1234, 2, 0,   1'b1, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 4, 32'h0000_0080, 1'b1, 1'b0});
    vt.push_back('{2'b10, 3'b001, 32'h8000_0022, 32'h0000_ABCD, 32'h0, -1, 0, 1'b1, 32'h8000_0020, 1'b1, 32'hABCD_ABCD, 4'b1100, 2, 32'h0, 1'b0, 1'b0});
    vt.push_back('{2'b01, 3'b010, 32'h8000_0002, 32'h0, 32'h1111_1111, 2, 0,   1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b01, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 2, 0,   1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 4, 32'hFFFF_8001, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b101, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 2, 0,   1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 4, 32'h0000_8001, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b000, 32'h8000_0008, 32'h0, 32'h0000_007F, 1, 0,   1'b1, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 3, 32'h0000_007F, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b010, 32'h8000_000C, 32'h0, 32'h1357_9BDF, 4, 0,   1'b1, 32'h8000_000C, 1'b0, 32'h0, 4'h0, 6, 32'h1357_9BDF, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b010, 32'h8000_0014, 32'h0, 32'h2468_ACE0, 16, 0,  1'b1, 32'h8000_0014, 1'b0, 32'h0, 4'h0, 18, 32'h2468_ACE0, 1'b1, 1'b0});
    vt.push_back('{2'b01, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 2, 0,           1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b10, 3'b000, 32'h8000_0031, 32'h1234_56A5, 32'h0, -1, 0, 1'b1, 32'h8000_0030, 1'b1, 32'hA5A5_A5A5, 4'b0010, 2, 32'h0, 1'b0, 1'b0});
    vt.push_back('{2'b10, 3'b010, 32'h8000_0040, 32'hCAFE_F00D, 32'h0, -1, 5, 1'b1, 32'h8000_0040, 1'b1, 32'hCAFE_F00D, 4'b1111, 2, 32'h0, 1'b0, 1'b0});
    vt.push_back('{2'b10, 3'b010, 32'h8000_0041, 32'hCAFE_F00D, 32'h0, -1, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b10, 3'b100, 32'h8000_0050, 32'h0000_00FF, 32'h0, -1, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b00, 3'b010, 32'h8000_0060, 32'h0, 32'h0, 2, 0,          1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b11, 3'b010, 32'h8000_0060, 32'h0, 32'h0, 2, 0,          1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b01, 3'b011, 32'h8000_0060, 32'h0, 32'h0, 2, 0,          1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1, 32'h0, 1'b0, 1'b1});
    vt.push_back('{2'b01, 3'b010, 32'h8000_0070, 32'h0, 32'h0, 2, 3,          1'b1, 32'h8000_0070, 1'b0, 32'h0, 4'h0, 4, 32'h0, 1'b1, 1'b0});

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_funct3 = 3'b000;
    bus.in_addr = 32'h0; bus.in_wdata = 32'h0; bus.in_rd = 5'd0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    cur = -1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Load with no read data at all: times out after 16 WAIT_R cycles.
    run_vec('{2'b01, 3'b010, 32'h8000_0080, 32'h0, 32'h5555_5555, -1, 0,
              1'b1, 32'h8000_0080, 1'b0, 32'h0, 4'h0, 18, 32'h0, 1'b0, 1'b1}, 100);
    // A late rvalid after the timeout must not produce anything.
    cur = 101;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stray_out_valid", 32'(bus.out_valid), 32'd0);
      chk("stray_in_ready",  32'(bus.in_ready),  32'd1);
      chk("stray_mem_req",   32'(bus.mem_req),   32'd0);
    end

    // Reset while a load waits for read data.
    cur = 102;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_funct3 = 3'b010;
    bus.in_addr = 32'h8000_0090; bus.in_rd = 5'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst_seq_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("after_rst_in_ready",  32'(bus.in_ready),  32'd1);
    end

    // The block recovers and serves a normal load.
    run_vec('{2'b01, 3'b010, 32'h8000_00A0, 32'h0, 32'h0BAD_F00D, 2, 0,
              1'b1, 32'h8000_00A0, 1'b0, 32'h0, 4'h0, 4, 32'h0BAD_F00D, 1'b1, 1'b0}, 103);

    cur = 104;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
